// File: rtl/tune.sv
// tune: six-note square-wave tune player.
// A level `start` seen in IDLE plays notes sd0..sd5 once, each lasting
// clockSpeed cycles (0 counts as 1). Each note is a 50%-duty square wave whose
// half-period equals its step value. A step of 0 is a rest.
// Control contract: there is no valid/ready pair. `start` is a level request
// consumed only in IDLE. DONE waits for `start` to drop, so a held request
// plays exactly once. dbg_state mirrors the FSM state (0 IDLE, 1 PLAY, 2 DONE).
module tune (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sd0,
  input  logic [7:0]  sd1,
  input  logic [7:0]  sd2,
  input  logic [7:0]  sd3,
  input  logic [7:0]  sd4,
  input  logic [7:0]  sd5,
  input  logic [35:0] clockSpeed,
  output logic        pwm,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  note_idx, note_idx_nx;
  logic [35:0] dur_cnt, dur_cnt_nx;
  logic [7:0]  tone_cnt, tone_cnt_nx;
  logic        pwm_nx;
  logic [7:0]  cur;
  logic [35:0] dur_last;
  logic        note_end;

  assign dbg_state = state;

  // Current note step, selected live so input changes act on the next clock.
  always_comb begin
    cur = 8'd0;
    case (note_idx)
      3'd0:    cur = sd0;
      3'd1:    cur = sd1;
      3'd2:    cur = sd2;
      3'd3:    cur = sd3;
      3'd4:    cur = sd4;
      3'd5:    cur = sd5;
      default: cur = 8'd0;
    endcase
  end

  // Last cycle index of a note; a zero tempo behaves as a one-cycle note.
  assign dur_last = (clockSpeed == 36'd0) ? 36'd0 : clockSpeed - 36'd1;
  // >= rather than == so a mid-note tempo decrease still ends the note.
  assign note_end = (dur_cnt >= dur_last);

  // Next-state, counter and waveform logic.
  always_comb begin
    state_nx    = state;
    note_idx_nx = note_idx;
    dur_cnt_nx  = dur_cnt;
    tone_cnt_nx = tone_cnt;
    pwm_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = PLAY;
          note_idx_nx = 3'd0;
          dur_cnt_nx  = 36'd0;
          tone_cnt_nx = 8'd0;
        end
      end
      PLAY: begin
        if (note_end) begin
          // Every note starts with a fresh, low wave.
          dur_cnt_nx  = 36'd0;
          tone_cnt_nx = 8'd0;
          pwm_nx      = 1'b0;
          if (note_idx == 3'd5) begin
            state_nx    = DONE;
            note_idx_nx = 3'd0;
          end else begin
            note_idx_nx = note_idx + 3'd1;
          end
        end else begin
          dur_cnt_nx = dur_cnt + 36'd1;
          if (cur == 8'd0) begin
            pwm_nx      = 1'b0;
            tone_cnt_nx = 8'd0;
          end else if (tone_cnt >= cur - 8'd1) begin
            // >= also catches a step lowered below the running count.
            pwm_nx      = ~pwm;
            tone_cnt_nx = 8'd0;
          end else begin
            pwm_nx      = pwm;
            tone_cnt_nx = tone_cnt + 8'd1;
          end
        end
      end
      DONE: begin
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      note_idx <= 3'd0;
      dur_cnt  <= 36'd0;
      tone_cnt <= 8'd0;
      pwm      <= 1'b0;
    end else begin
      state    <= state_nx;
      note_idx <= note_idx_nx;
      dur_cnt  <= dur_cnt_nx;
      tone_cnt <= tone_cnt_nx;
      pwm      <= pwm_nx;
    end
  end

endmodule

// File: tb/tb_tune.sv
// tb_tune: directed scenarios for the tune player. Expected pwm samples for
// every PLAY cycle are queued when a tune is launched; a monitor pops one per
// PLAY cycle and compares.
module tb_tune;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sd0, sd1, sd2, sd3, sd4, sd5;
  logic [35:0] clockSpeed;
  logic        pwm;
  logic [1:0]  dbg_state;

  logic [0:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;
  int play_seen = 0;

  tune dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sd0        (sd0),
    .sd1        (sd1),
    .sd2        (sd2),
    .sd3        (sd3),
    .sd4        (sd4),
    .sd5        (sd5),
    .clockSpeed (clockSpeed),
    .pwm        (pwm),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Monitor: one expected pwm sample per PLAY cycle.
  always @(negedge clk) begin
    if (dbg_state == S_PLAY) begin
      play_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL play_unexpected: pwm=%0b while no note expected (t=%0t)", pwm, $time);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if (pwm !== e) begin
          errors++;
          $display("FAIL play_pwm: got %0b expected %0b (play cycle %0d, t=%0t)",
                   pwm, e, play_seen - 1, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Queue one note of step s lasting dur cycles.
  task automatic push_note(input int s, input int dur);
    for (int j = 0; j < dur; j++)
      exp_q.push_back((s == 0) ? 1'b0 : 1'(((j / s) % 2)));
  endtask

  task automatic push_tune(input int s0, input int s1, input int s2, input int s3,
                           input int s4, input int s5, input int cs);
    int dur;
    dur = (cs == 0) ? 1 : cs;
    push_note(s0, dur); push_note(s1, dur); push_note(s2, dur);
    push_note(s3, dur); push_note(s4, dur); push_note(s5, dur);
  endtask

  task automatic set_sd(input int s0, input int s1, input int s2, input int s3,
                        input int s4, input int s5, input int cs);
    sd0 = 8'(s0); sd1 = 8'(s1); sd2 = 8'(s2);
    sd3 = 8'(s3); sd4 = 8'(s4); sd5 = 8'(s5);
    clockSpeed = 36'(cs);
  endtask

  // Raise start at a negedge; PLAY begins after the next posedge.
  task automatic launch();
    play_seen = 0;
    start = 1'b1;
  endtask

  // Wait (bounded) for DONE, then check PLAY length and quiet output.
  task automatic wait_done(input string name, input int exp_play);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); #1;
      if (dbg_state == S_DONE) seen = 1;
    end
    if (!seen) begin
      errors++; vectors++;
      $display("FAIL %s_timeout: state %0d, DONE never reached", name, dbg_state);
    end else begin
      check({name, "_play_cycles"}, 36'(play_seen), 36'(exp_play));
      check({name, "_done_pwm"}, 36'(pwm), 36'd0);
    end
  endtask

  // Drop start for one cycle and confirm return to IDLE.
  task automatic back_to_idle(input string name);
    start = 1'b0;
    @(negedge clk); #1;
    check({name, "_idle_state"}, 36'(dbg_state), 36'(S_IDLE));
    check({name, "_idle_pwm"}, 36'(pwm), 36'd0);
  endtask

  // Stimulus driver
  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_sd(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 36'(dbg_state), 36'(S_IDLE));
    check("reset_pwm", 36'(pwm), 36'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("idle_no_start", 36'(dbg_state), 36'(S_IDLE));

    // Reference playback, start held throughout.
    set_sd(5, 10, 8, 15, 5, 5, 20);
    push_tune(5, 10, 8, 15, 5, 5, 20);
    launch();
    wait_done("ref", 120);
    repeat (10) @(negedge clk);
    #1;
    check("ref_no_replay", 36'(dbg_state), 36'(S_DONE));
    check("ref_hold_pwm", 36'(pwm), 36'd0);

    // Retrigger: identical second pass.
    back_to_idle("retrig");
    push_tune(5, 10, 8, 15, 5, 5, 20);
    launch();
    wait_done("retrig", 120);

    // Rest note and step of 1.
    back_to_idle("rest");
    set_sd(2, 3, 0, 1, 2, 3, 6);
    push_tune(2, 3, 0, 1, 2, 3, 6);
    launch();
    wait_done("rest", 36);

    // Zero tempo: one cycle per note.
    back_to_idle("zero");
    set_sd(5, 10, 8, 15, 5, 5, 0);
    push_tune(5, 10, 8, 15, 5, 5, 0);
    launch();
    wait_done("zero", 6);

    // Reset while pwm is high in note 1 (play cycle 32), start kept high.
    back_to_idle("rst");
    set_sd(5, 10, 8, 15, 5, 5, 20);
    push_note(5, 20);
    push_note(10, 13);
    launch();
    for (int i = 0; i < 200 && play_seen < 33; i++) begin
      @(negedge clk); #1;
    end
    check("rst_pwm_high", 36'(pwm), 36'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rst_state", 36'(dbg_state), 36'(S_IDLE));
    check("rst_pwm", 36'(pwm), 36'd0);
    check("rst_queue_drained", 36'(exp_q.size()), 36'd0);
    push_tune(5, 10, 8, 15, 5, 5, 20);
    play_seen = 0;
    reset = 1'b0;
    wait_done("rst_restart", 120);

    // Live step change: sd0 15 -> 3 while toneCnt = 10.
    back_to_idle("live");
    set_sd(15, 4, 4, 4, 4, 4, 40);
    for (int j = 0; j < 40; j++)
      exp_q.push_back((j <= 10) ? 1'b0 : 1'((((j - 11) / 3) % 2) == 0));
    for (int n = 0; n < 5; n++) push_note(4, 40);
    launch();
    for (int i = 0; i < 200 && play_seen < 11; i++) begin
      @(negedge clk); #1;
    end
    sd0 = 8'd3;
    wait_done("live", 240);

    back_to_idle("end");
    repeat (3) @(negedge clk);
    #1;
    check("queue_empty", 36'(exp_q.size()), 36'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
